n1_ifu_prefetch: RTL and testbench

Instruction prefetch unit that writes the pre-decoded instruction queue. It keeps the fetch PC and issues word reads on the instruction memory bus. It pushes returned words into the queue through a write strobe and tracks the queue write pointer against the decoder's read pointer so the queue never overflows. On a taken branch/jump it retargets fetch, discards stale responses and publishes the queue slot where post-redirect instructions will land. It sits between instruction memory and the decode unit's 8-entry queue.

---
 rtl/n1_ifu_prefetch.sv | 131 +++++++++++++
 tb/tb_n1_ifu_prefetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/n1_ifu_prefetch.sv
// Instruction prefetch: one outstanding word read, pushes into the decode queue.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module n1_ifu_prefetch #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter int unsigned IQ_PTR_BITS    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   mem_valid_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_ready_i,
  input  logic [31:0]            mem_rdata_i,
  output logic                   instr_ready_o,
  output logic [31:0]            instr_rdata_o,
  input  logic [IQ_PTR_BITS-1:0] iq_rd_ptr_i,
  output logic [IQ_PTR_BITS-1:0] iq_wr_ptr_o,
  output logic [IQ_PTR_BITS-1:0] iq_prefetch_ptr_o,
  output logic                   fetch_misalign_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FULL  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [IQ_PTR_BITS-1:0] CNT_FULL = '1;
  localparam logic [IQ_PTR_BITS-1:0] PTR_ONE  = IQ_PTR_BITS'(1);

  logic [2:0]             r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_stale_addr;
  logic [IQ_PTR_BITS-1:0] r_wr_ptr;
  logic                   r_halt_pend;
  logic                   r_misalign;

  logic [IQ_PTR_BITS-1:0] w_count;
  logic [IQ_PTR_BITS-1:0] w_count_inc;
  logic                   w_full;
  logic                   w_full_after;
  logic [2:0]             w_resume;
  logic [31:0]            w_target;
  logic                   w_trap;

  assign w_count      = r_wr_ptr - iq_rd_ptr_i;
  assign w_count_inc  = w_count + PTR_ONE;
  assign w_full       = (w_count == CNT_FULL);
  assign w_full_after = (w_count_inc == CNT_FULL);
  assign w_resume     = w_full ? S_FULL : S_REQ;

`ifdef IFU_MISALIGN_TRAP_EN
  assign w_target         = redirect_pc_i;
  assign w_trap           = redirect_i && (r_state != S_HALT) && (redirect_pc_i[1:0] != 2'b00);
  assign fetch_misalign_o = r_misalign;
`else
  logic [2:0] w_unused_bits;
  assign w_target         = {redirect_pc_i[31:2], 2'b00};
  assign w_trap           = 1'b0;
  assign fetch_misalign_o = 1'b0;
  assign w_unused_bits    = {redirect_pc_i[1:0], r_misalign};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_pc         <= PROGADDR_RESET;
      r_stale_addr <= PROGADDR_RESET;
      r_wr_ptr     <= '0;
      r_halt_pend  <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      if (w_trap) r_misalign <= 1'b1;
      case (r_state)
        S_IDLE, S_FULL: begin
          if (redirect_i) r_pc <= w_target;
          if (w_trap) begin
            r_state     <= S_HALT;
            r_halt_pend <= 1'b0;
          end else begin
            r_state <= w_resume;
          end
        end
        S_REQ: begin
          if (w_trap) begin
            // an unanswered request must still be drained before going quiet
            r_state      <= S_HALT;
            r_halt_pend  <= !mem_ready_i;
            r_stale_addr <= r_pc;
            r_pc         <= w_target;
          end else if (redirect_i) begin
            r_pc <= w_target;
            if (mem_ready_i) begin
              r_state <= w_resume;
            end else begin
              r_stale_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (mem_ready_i) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_pc     <= r_pc + 32'd4;
            r_state  <= w_full_after ? S_FULL : S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect_i) r_pc <= w_target;
          if (w_trap) begin
            r_state     <= S_HALT;
            r_halt_pend <= !mem_ready_i;
          end else if (mem_ready_i) begin
            r_state <= w_resume;
          end
        end
        S_HALT: begin
          if (mem_ready_i) r_halt_pend <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // DRAIN and HALT keep presenting the abandoned address until it completes
  assign mem_valid_o = (r_state == S_REQ) || (r_state == S_DRAIN) ||
                       ((r_state == S_HALT) && r_halt_pend);
  assign mem_addr_o  = ((r_state == S_DRAIN) || (r_state == S_HALT)) ? r_stale_addr : r_pc;

  assign instr_ready_o     = (r_state == S_REQ) && mem_ready_i && !redirect_i;
  assign instr_rdata_o     = mem_rdata_i;
  assign iq_wr_ptr_o       = r_wr_ptr;
  assign iq_prefetch_ptr_o = r_wr_ptr;
endmodule

// File: tb/tb_n1_ifu_prefetch.sv
// Bench for n1_ifu_prefetch: transaction-level model checked every cycle plus directed literals.
module tb_n1_ifu_prefetch;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        instr_ready_o;
  logic [31:0] instr_rdata_o;
  logic [2:0]  iq_rd_ptr_i = 3'd0;
  logic [2:0]  iq_wr_ptr_o;
  logic [2:0]  iq_prefetch_ptr_o;
  logic        fetch_misalign_o;

  n1_ifu_prefetch #(.PROGADDR_RESET(32'h0), .IQ_PTR_BITS(3)) dut (
    .clk(clk), .resetn(resetn), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .instr_ready_o(instr_ready_o), .instr_rdata_o(instr_rdata_o),
    .iq_rd_ptr_i(iq_rd_ptr_i), .iq_wr_ptr_o(iq_wr_ptr_o),
    .iq_prefetch_ptr_o(iq_prefetch_ptr_o), .fetch_misalign_o(fetch_misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // stimulus controls, written only by the main initial block
  int         lat = 1;
  bit         consume = 1'b0;
  logic [2:0] rd_target = 3'd0;

  // memory responder and queue reader: addr-as-data, fixed latency
  int c = 0;
  always begin
    @(posedge clk); #2;
    if (!resetn) begin
      mem_ready_i = 1'b0; c = 0; iq_rd_ptr_i = 3'd0;
    end else begin
      if (!mem_valid_o) begin
        mem_ready_i = 1'b0; c = 0;
      end else begin
        mem_ready_i = (c >= lat - 1);
        c = mem_ready_i ? 0 : c + 1;
      end
      if (consume) begin
        if (iq_wr_ptr_o != iq_rd_ptr_i) iq_rd_ptr_i = iq_rd_ptr_i + 3'd1;
      end else begin
        iq_rd_ptr_i = rd_target;
      end
    end
    mem_rdata_i = mem_addr_o;
  end

  // model: outstanding transaction (valid/addr/stale), fetch pc, write slot, halt
  bit          m_init = 1'b0;
  bit          m_ov, m_os, m_halt, m_mis;
  logic [31:0] m_oa, m_pc, tgt;
  logic [2:0]  m_wr;
  logic [2:0]  log_slot[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    if (m_init) begin
      chk("mem_valid", mem_valid_o, m_ov);
      if (m_ov) chk("mem_addr", mem_addr_o, m_oa);
      chk("instr_ready", instr_ready_o, m_ov && !m_os && mem_ready_i && !redirect_i);
      if (m_ov && !m_os && mem_ready_i && !redirect_i) chk("instr_rdata", instr_rdata_o, m_oa);
      chk("wr_ptr", iq_wr_ptr_o, m_wr);
      chk("prefetch_ptr", iq_prefetch_ptr_o, m_wr);
      chk("misalign", fetch_misalign_o, m_mis);
      if (instr_ready_o) begin
        chk("no_overflow", 32'(3'(iq_wr_ptr_o - iq_rd_ptr_i) != 3'd7), 32'd1);
        log_slot.push_back(iq_wr_ptr_o);
        log_data.push_back(instr_rdata_o);
      end
    end
    if (!resetn) begin
      m_init = 1'b1; m_ov = 1'b0; m_os = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
      m_oa = 32'h0; m_pc = 32'h0; m_wr = 3'd0;
      log_slot.delete(); log_data.delete();
    end else begin
      if (m_ov && mem_ready_i) begin
        if (!m_os && !redirect_i) begin m_wr = m_wr + 3'd1; m_pc = m_pc + 32'd4; end
        m_ov = 1'b0;
      end
      if (redirect_i && !m_halt) begin
        tgt = redirect_pc_i;
`ifdef IFU_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin m_halt = 1'b1; m_mis = 1'b1; end
`else
        tgt[1:0] = 2'b00;
`endif
        m_pc = tgt;
        if (m_ov) m_os = 1'b1;
      end
      if (!m_halt && !m_ov && 3'(m_wr - iq_rd_ptr_i) != 3'd7) begin
        m_ov = 1'b1; m_oa = m_pc; m_os = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input bit cons);
    resetn = 1'b0; redirect_i = 1'b0; rd_target = 3'd0;
    tick(3);
    lat = l; consume = cons;
    resetn = 1'b1;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_i = 1'b1; redirect_pc_i = a;
    tick(1);
    redirect_i = 1'b0;
  endtask

  initial begin
    // zero-wait fill until full, then resume and redirect from FULL
    resetn = 1'b0;
    tick(2);
    chk("rst_valid", mem_valid_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wr", iq_wr_ptr_o, 3'd0);
    do_reset(1, 1'b0);
    tick(1);
    chk("first_req_addr", mem_addr_o, 32'h0);
    tick(9);
    chk("fill_wr", iq_wr_ptr_o, 3'd7);
    chk("fill_valid", mem_valid_o, 1'b0);
    chk("fill_len", log_data.size(), 7);
    for (int k = 0; k < 7; k++) begin
      chk("fill_slot", log_slot[k], k);
      chk("fill_data", log_data[k], 4 * k);
    end
    rd_target = 3'd1;
    tick(1);
    chk("resume_valid", mem_valid_o, 1'b1);
    chk("resume_addr", mem_addr_o, 32'h1C);
    tick(1);
    chk("wrap_wr", iq_wr_ptr_o, 3'd0);
    chk("refull_valid", mem_valid_o, 1'b0);
    chk("slot7_data", log_data[7], 32'h1C);
    redir(32'h300);
    chk("full_redir_valid", mem_valid_o, 1'b0);
    chk("full_redir_pref", iq_prefetch_ptr_o, 3'd0);
    rd_target = 3'd2;
    tick(1);
    chk("full_redir_addr", mem_addr_o, 32'h300);
    tick(1);
    chk("full_redir_slot", log_slot[8], 3'd0);
    chk("full_redir_data", log_data[8], 32'h300);

    // 3-cycle latency: one word every 3 cycles
    do_reset(3, 1'b1);
    tick(16);
    chk("lat3_wr", iq_wr_ptr_o, 3'd5);
    chk("lat3_len", log_data.size(), 5);
    for (int k = 0; k < 5; k++) chk("lat3_data", log_data[k], 4 * k);

    // redirect while request to 0x8 is pending
    do_reset(3, 1'b0);
    tick(8);
    chk("pend_addr", mem_addr_o, 32'h8);
    redir(32'h100);
    chk("drain_pref", iq_prefetch_ptr_o, 3'd2);
    chk("drain_addr", mem_addr_o, 32'h8);
    chk("drain_valid", mem_valid_o, 1'b1);
    tick(1);
    chk("post_drain_addr", mem_addr_o, 32'h100);
    chk("post_drain_wr", iq_wr_ptr_o, 3'd2);
    tick(3);
    chk("redir_wr", iq_wr_ptr_o, 3'd3);
    chk("redir_slot2", log_data[2], 32'h100);

    // redirect coincident with mem_ready_i
    do_reset(1, 1'b1);
    tick(3);
    chk("coin_pref", iq_prefetch_ptr_o, 3'd2);
    redir(32'h200);
    chk("coin_wr", iq_wr_ptr_o, 3'd2);
    chk("coin_addr", mem_addr_o, 32'h200);
    tick(1);
    chk("coin_wr2", iq_wr_ptr_o, 3'd3);
    chk("coin_data", log_data[2], 32'h200);

    // pointer wrap with continuous consumption
    do_reset(1, 1'b1);
    tick(22);
    chk("wrap_len_ok", 32'(log_data.size() >= 20), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk("wrap_slot", log_slot[k], k % 8);
      chk("wrap_data", log_data[k], 4 * k);
    end

    // misaligned redirect
    redir(32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("mis_flag", fetch_misalign_o, 1'b1);
    chk("mis_valid", mem_valid_o, 1'b0);
    tick(5);
    chk("mis_valid_hold", mem_valid_o, 1'b0);
    chk("mis_flag_hold", fetch_misalign_o, 1'b1);
`else
    chk("mis_flag", fetch_misalign_o, 1'b0);
    chk("mis_addr", mem_addr_o, 32'h100);
    tick(1);
    chk("mis_next_addr", mem_addr_o, 32'h104);
`endif
    do_reset(1, 1'b0);
    chk("final_rst_flag", fetch_misalign_o, 1'b0);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
